binary_to_gray_counter: RTL and testbench



---
 rtl/binary_to_gray_pkg.sv | 18 +
 rtl/binary_to_gray.sv | 14 +
 rtl/binary_to_gray_counter.sv | 119 +++++++++++
 tb/tb_binary_to_gray_counter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_to_gray_pkg.sv
// Shared types and the Gray encoding function for the binary-to-Gray counter.
package binary_to_gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;
    // Widest value the shared encoding function handles.
    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Reflected binary code: each bit is XORed with its upper neighbour.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational WIDTH-bit binary to Gray encoder (WIDTH up to MAX_WIDTH).
module binary_to_gray
    import binary_to_gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Widen into the shared function and keep only the low WIDTH bits.
    assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/binary_to_gray_counter.sv
// Loadable up/down Gray counter with a programmable step period.
// A load converts and registers a binary value; RUN steps the count every DIV cycles.
module binary_to_gray_counter
    import binary_to_gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             start,
    input  logic             stop,
    input  logic             up_down,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             gray_valid,
    output logic             wrap,
    output logic             busy
);

    // A 1-cycle period still needs a 1-bit prescaler to keep the vector legal.
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BIN_ZERO = '0;

    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             valid_q;
    logic             wrap_q;
    logic [PW-1:0]    presc_q;

    logic             load_fire;
    logic             step_fire;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Select the next binary value: load in IDLE, or one step in RUN unless stop is present.
    always_comb begin
        load_fire = (state_q == IDLE) && load_valid;
        step_fire = (state_q == RUN) && !stop && (presc_q == PRESC_MAX);
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (load_fire) begin
            bin_next = load_bin;
        end else if (step_fire) begin
            if (up_down) begin
                bin_next  = bin_q + WIDTH'(1);
                wrap_next = (bin_q == BIN_MAX);
            end else begin
                bin_next  = bin_q - WIDTH'(1);
                wrap_next = (bin_q == BIN_ZERO);
            end
        end
    end

    binary_to_gray #(
        .WIDTH(WIDTH)
    ) u_encoder (
        .bin (bin_next),
        .gray(gray_next)
    );

    // State, prescaler and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            valid_q <= load_fire | step_fire;
            wrap_q  <= wrap_next;
            if (load_fire || step_fire) begin
                bin_q  <= bin_next;
                gray_q <= gray_next;
            end
            unique case (state_q)
                IDLE: begin
                    // A load in the same cycle takes priority over start.
                    if (!load_valid && start) begin
                        state_q <= RUN;
                        presc_q <= '0;
                    end
                end
                RUN: begin
                    // stop beats both start and a pending step.
                    if (stop) begin
                        state_q <= IDLE;
                        presc_q <= '0;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign gray_out   = gray_q;
    assign bin_out    = bin_q;
    assign gray_valid = valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Scoreboard bench for binary_to_gray_counter: a DIV=1 and a DIV=4 instance share stimulus.
module tb_binary_to_gray_counter;

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] b;
        logic       w;
        logic       step;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lv = 1'b0, st = 1'b0, sp = 1'b0, ud = 1'b0;
    logic [2:0] lb = 3'b000;

    logic       rd1, v1, w1, bz1;
    logic [2:0] g1, b1;
    logic       rd4, v4, w4, bz4;
    logic [2:0] g4, b4;

    int total = 0;
    int bad = 0;
    bit mon1_en = 1'b0;
    bit mon4_en = 1'b0;
    exp_t q1[$];
    exp_t q4[$];
    logic [2:0] last1 = 3'b000;
    logic [2:0] last4 = 3'b000;

    always #5 clk = ~clk;

    binary_to_gray_counter #(.WIDTH(3), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rd1), .load_bin(lb),
        .start(st), .stop(sp), .up_down(ud), .gray_out(g1), .bin_out(b1),
        .gray_valid(v1), .wrap(w1), .busy(bz1)
    );

    binary_to_gray_counter #(.WIDTH(3), .DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rd4), .load_bin(lb),
        .start(st), .stop(sp), .up_down(ud), .gray_out(g4), .bin_out(b4),
        .gray_valid(v4), .wrap(w4), .busy(bz4)
    );

    function automatic exp_t mk(input logic [2:0] g, input logic [2:0] b, input logic w,
                                input logic s);
        exp_t e;
        e.g = g; e.b = b; e.w = w; e.step = s;
        return e;
    endfunction

    // Scoreboard for the DIV=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mon1_en) begin
            if (w1 && !v1) begin
                total++; bad++;
                $display("FAIL dut1_wrap_without_valid wrap=%b valid=%b", w1, v1);
            end
            if (v1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL dut1_unexpected_valid gray=%b bin=%b", g1, b1);
                end else begin
                    e = q1.pop_front();
                    if ({g1, b1, w1} !== {e.g, e.b, e.w}) begin
                        bad++;
                        $display("FAIL dut1_output got g=%b b=%b w=%b want g=%b b=%b w=%b",
                                 g1, b1, w1, e.g, e.b, e.w);
                    end
                    if (e.step) begin
                        total++;
                        if ($countones(last1 ^ g1) != 1) begin
                            bad++;
                            $display("FAIL dut1_one_bit_step prev=%b got=%b", last1, g1);
                        end
                    end
                end
            end
        end
        last1 = g1;
    end

    // Scoreboard for the DIV=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mon4_en) begin
            if (v4) begin
                total++;
                if (q4.size() == 0) begin
                    bad++;
                    $display("FAIL dut4_unexpected_valid gray=%b bin=%b", g4, b4);
                end else begin
                    e = q4.pop_front();
                    if ({g4, b4, w4} !== {e.g, e.b, e.w}) begin
                        bad++;
                        $display("FAIL dut4_output got g=%b b=%b w=%b want g=%b b=%b w=%b",
                                 g4, b4, w4, e.g, e.b, e.w);
                    end
                    if (e.step) begin
                        total++;
                        if ($countones(last4 ^ g4) != 1) begin
                            bad++;
                            $display("FAIL dut4_one_bit_step prev=%b got=%b", last4, g4);
                        end
                    end
                end
            end
        end
        last4 = g4;
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        lv = 1'b0; st = 1'b0; sp = 1'b0; ud = 1'b0; lb = 3'b000;
        q1.delete();
        q4.delete();
        #4;
        rst = 1'b0;
    endtask

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mon1_en = 1'b1; mon4_en = 1'b0;
        do_reset();
        total++;
        if ({g1, b1, v1, w1, bz1, rd1} !== 10'b000_000_0_0_0_1) begin
            bad++;
            $display("FAIL reset_dut1 got %b want 0000000001", {g1, b1, v1, w1, bz1, rd1});
        end
        total++;
        if ({g4, b4, v4, w4, bz4, rd4} !== 10'b000_000_0_0_0_1) begin
            bad++;
            $display("FAIL reset_dut4 got %b want 0000000001", {g4, b4, v4, w4, bz4, rd4});
        end
        lv = 1'b1; lb = 3'd5;
        q1.push_back(mk(3'b111, 3'b101, 1'b0, 1'b0));
        edge_n(1);
        lv = 1'b0;
        total++;
        if (rd1 !== 1'b1) begin bad++; $display("FAIL load_ready_after_load got %b want 1", rd1); end
        @(negedge clk); #1;
        total++;
        if ({g1, b1, v1} !== 7'b111_101_1) begin
            bad++;
            $display("FAIL load5_result got g=%b b=%b v=%b want 111 101 1", g1, b1, v1);
        end
        @(negedge clk); #1;
        total++;
        if ({g1, v1, rd1} !== 5'b111_0_1) begin
            bad++;
            $display("FAIL load5_pulse_once got g=%b v=%b rdy=%b want 111 0 1", g1, v1, rd1);
        end
        total++;
        if (q1.size() != 0) begin bad++; $display("FAIL load5_missing got %0d left want 0", q1.size()); end
    endtask

    task automatic test_up_wrap();
        mon1_en = 1'b1; mon4_en = 1'b0;
        do_reset();
        lv = 1'b1; lb = 3'd6;
        q1.push_back(mk(3'b101, 3'b110, 1'b0, 1'b0));
        edge_n(1);
        lv = 1'b0; st = 1'b1; ud = 1'b1;
        q1.push_back(mk(3'b100, 3'b111, 1'b0, 1'b1));
        q1.push_back(mk(3'b000, 3'b000, 1'b1, 1'b1));
        q1.push_back(mk(3'b001, 3'b001, 1'b0, 1'b1));
        edge_n(1);
        st = 1'b0;
        total++;
        if (bz1 !== 1'b1 || rd1 !== 1'b0) begin
            bad++;
            $display("FAIL up_run_flags got busy=%b rdy=%b want 1 0", bz1, rd1);
        end
        edge_n(3);
        sp = 1'b1;
        edge_n(1);
        sp = 1'b0;
        edge_n(2);
        total++;
        if ({g1, b1, bz1, rd1} !== 8'b001_001_0_1) begin
            bad++;
            $display("FAIL up_stop_hold got g=%b b=%b busy=%b rdy=%b want 001 001 0 1",
                     g1, b1, bz1, rd1);
        end
        total++;
        if (q1.size() != 0) begin bad++; $display("FAIL up_missing got %0d left want 0", q1.size()); end
    endtask

    task automatic test_down_wrap();
        mon1_en = 1'b1; mon4_en = 1'b0;
        do_reset();
        lv = 1'b1; lb = 3'd0;
        q1.push_back(mk(3'b000, 3'b000, 1'b0, 1'b0));
        edge_n(1);
        lv = 1'b0; st = 1'b1; ud = 1'b0;
        q1.push_back(mk(3'b100, 3'b111, 1'b1, 1'b1));
        edge_n(1);
        st = 1'b0;
        edge_n(1);
        // start together with stop counts as stop
        st = 1'b1; sp = 1'b1;
        edge_n(1);
        st = 1'b0; sp = 1'b0;
        total++;
        if ({g1, b1, bz1} !== 7'b100_111_0) begin
            bad++;
            $display("FAIL down_wrap_stop got g=%b b=%b busy=%b want 100 111 0", g1, b1, bz1);
        end
        total++;
        if (q1.size() != 0) begin bad++; $display("FAIL down_missing got %0d left want 0", q1.size()); end
    endtask

    task automatic test_prescaler();
        mon1_en = 1'b0; mon4_en = 1'b1;
        do_reset();
        lv = 1'b1; lb = 3'd0;
        q4.push_back(mk(3'b000, 3'b000, 1'b0, 1'b0));
        edge_n(1);
        lv = 1'b0; st = 1'b1; ud = 1'b1;
        q4.push_back(mk(3'b001, 3'b001, 1'b0, 1'b1));
        q4.push_back(mk(3'b011, 3'b010, 1'b0, 1'b1));
        edge_n(1);
        st = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            if (i == 10) begin #1; sp = 1'b1; end
            @(negedge clk); #1;
            total++;
            if (v4 !== ((i % 4) == 3)) begin
                bad++;
                $display("FAIL presc_period cycle=%0d got valid=%b want %b", i, v4, (i % 4) == 3);
            end
        end
        // the next edge would be a step; stop must suppress it
        @(posedge clk); #1;
        sp = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({g4, b4, v4, bz4, rd4} !== 9'b011_010_0_0_1) begin
            bad++;
            $display("FAIL presc_stop_wins got g=%b b=%b v=%b busy=%b rdy=%b want 011 010 0 0 1",
                     g4, b4, v4, bz4, rd4);
        end
        total++;
        if (q4.size() != 0) begin bad++; $display("FAIL presc_missing got %0d left want 0", q4.size()); end
    endtask

    task automatic test_priority();
        mon1_en = 1'b1; mon4_en = 1'b0;
        do_reset();
        lv = 1'b1; lb = 3'd3; st = 1'b1;
        q1.push_back(mk(3'b010, 3'b011, 1'b0, 1'b0));
        edge_n(1);
        lv = 1'b0; st = 1'b0;
        edge_n(1);
        total++;
        if (bz1 !== 1'b0 || rd1 !== 1'b1) begin
            bad++;
            $display("FAIL load_over_start got busy=%b rdy=%b want 0 1", bz1, rd1);
        end
        st = 1'b1; ud = 1'b1;
        q1.push_back(mk(3'b110, 3'b100, 1'b0, 1'b1));
        q1.push_back(mk(3'b111, 3'b101, 1'b0, 1'b1));
        edge_n(1);
        st = 1'b0; lv = 1'b1; lb = 3'd6;
        @(negedge clk); #1;
        total++;
        if (rd1 !== 1'b0) begin bad++; $display("FAIL run_ready got %b want 0", rd1); end
        edge_n(1);
        edge_n(1);
        sp = 1'b1; lv = 1'b0;
        edge_n(1);
        sp = 1'b0;
        total++;
        if ({g1, b1} !== 6'b111_101) begin
            bad++;
            $display("FAIL run_load_ignored got g=%b b=%b want 111 101", g1, b1);
        end
        total++;
        if (q1.size() != 0) begin bad++; $display("FAIL prio_missing got %0d left want 0", q1.size()); end
    endtask

    task automatic test_async_reset();
        mon1_en = 1'b0; mon4_en = 1'b0;
        do_reset();
        lv = 1'b1; lb = 3'd2;
        edge_n(1);
        lv = 1'b0; st = 1'b1; ud = 1'b1;
        edge_n(1);
        st = 1'b0;
        @(posedge clk); #3;
        total++;
        if (bz1 !== 1'b1 || v1 !== 1'b1 || bz4 !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_run got busy1=%b v1=%b busy4=%b want 1 1 1", bz1, v1, bz4);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({g1, b1, v1, w1, bz1, rd1} !== 10'b000_000_0_0_0_1) begin
            bad++;
            $display("FAIL async_reset_dut1 got %b want 0000000001", {g1, b1, v1, w1, bz1, rd1});
        end
        total++;
        if ({g4, b4, v4, w4, bz4, rd4} !== 10'b000_000_0_0_0_1) begin
            bad++;
            $display("FAIL async_reset_dut4 got %b want 0000000001", {g4, b4, v4, w4, bz4, rd4});
        end
        #3;
        rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({g1, v1, bz1, rd1} !== 6'b000_0_0_1) begin
            bad++;
            $display("FAIL post_reset_idle got g=%b v=%b busy=%b rdy=%b want 000 0 0 1",
                     g1, v1, bz1, rd1);
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_prescaler();
        test_priority();
        test_async_reset();
        mon1_en = 1'b0; mon4_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
